// File: rtl/gci_std_display_bus_if_pkg.sv
// Shared definitions for the display bus front end.
//   - Default region bounds for the address decoder.
//   - IRQ codes reported for illegal accesses.
//   - Region type and the decode helper used by gci_std_display_bus_if.
package gci_std_display_bus_if_pkg;

  localparam logic [31:0] DEF_SPECIAL_END = 32'h0000_0400;
  localparam logic [31:0] DEF_DISP_LAST   = 32'h0013_83FC;

  localparam logic [23:0] IRQCODE_MEMOVER = 24'h00_0000;
  localparam logic [23:0] IRQCODE_READACC = 24'h00_0001;

  typedef enum logic [1:0] {
    REGION_SPECIAL,
    REGION_DISP,
    REGION_ILLEGAL
  } region_t;

  // Byte offset bits are don't-care: OR-ing them into the upper bound makes
  // every byte of the last display word decode as display space.
  function automatic region_t decodeRegion(input logic [31:0] addr,
                                           input logic [31:0] specialEnd,
                                           input logic [31:0] dispLast);
    if (addr < specialEnd)
      return REGION_SPECIAL;
    else if (addr > (dispLast | 32'h0000_0003))
      return REGION_ILLEGAL;
    else
      return REGION_DISP;
  endfunction

endpackage

// File: rtl/gci_std_display_bus_if_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   iCLOCK, iRESET_SYNC : clock, synchronous active-high reset (flushes pointers)
//   iWR_EN, iWR_DATA    : push request / data (ignored while full)
//   iRD_EN              : pop request (ignored while empty)
//   oRD_DATA            : current head entry
//   oFULL, oEMPTY       : occupancy flags
module gci_std_display_sync_fifo #(
  parameter int unsigned P_N       = 62,
  parameter int unsigned P_DEPTH   = 8,
  parameter int unsigned P_DEPTH_N = 3
) (
  input  logic           iCLOCK,
  input  logic           iRESET_SYNC,
  input  logic           iWR_EN,
  input  logic [P_N-1:0] iWR_DATA,
  output logic           oFULL,
  input  logic           iRD_EN,
  output logic [P_N-1:0] oRD_DATA,
  output logic           oEMPTY
);

  logic [P_N-1:0]   mem [P_DEPTH];
  logic [P_DEPTH_N:0] wrPtr;
  logic [P_DEPTH_N:0] rdPtr;
  logic push;
  logic pop;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
  assign oEMPTY   = (wrPtr == rdPtr);
  assign oFULL    = (wrPtr[P_DEPTH_N] != rdPtr[P_DEPTH_N]) &&
                    (wrPtr[P_DEPTH_N-1:0] == rdPtr[P_DEPTH_N-1:0]);
  assign push     = iWR_EN & ~oFULL;
  assign pop      = iRD_EN & ~oEMPTY;
  assign oRD_DATA = mem[rdPtr[P_DEPTH_N-1:0]];

  always_ff @(posedge iCLOCK) begin
    if (push) mem[wrPtr[P_DEPTH_N-1:0]] <= iWR_DATA;
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
    end
  end

endmodule

// File: rtl/gci_std_display_bus_if.sv
// Bus-slave front end for the display device.
//   iDEV_* / oDEV_*         : GCI bus request, response and back-pressure
//   oDEV_IRQ_* / iDEV_IRQ_* : IRQ request channel for illegal accesses
//   oSPECIAL_* / iSPECIAL_* : special-memory port (read data one cycle later)
//   oDISP_WR_* / iDISP_WR_* : buffered display writes toward the controller
module gci_std_display_bus_if
  import gci_std_display_bus_if_pkg::*;
#(
  parameter logic [31:0] P_SPECIAL_END = DEF_SPECIAL_END,
  parameter logic [31:0] P_DISP_LAST   = DEF_DISP_LAST,
  parameter int unsigned P_FIFO_DEPTH  = 8,
  parameter int unsigned P_FIFO_AW     = 3
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iDEV_REQ,
  output logic        oDEV_BUSY,
  input  logic        iDEV_RW,
  input  logic [31:0] iDEV_ADDR,
  input  logic [31:0] iDEV_DATA,
  output logic        oDEV_REQ,
  input  logic        iDEV_BUSY,
  output logic [31:0] oDEV_DATA,
  output logic        oDEV_IRQ_REQ,
  input  logic        iDEV_IRQ_BUSY,
  output logic [23:0] oDEV_IRQ_DATA,
  input  logic        iDEV_IRQ_ACK,
  output logic        oSPECIAL_REQ,
  output logic        oSPECIAL_RW,
  output logic [7:0]  oSPECIAL_ADDR,
  output logic [31:0] oSPECIAL_DATA,
  input  logic [31:0] iSPECIAL_DATA,
  output logic        oDISP_WR_REQ,
  input  logic        iDISP_WR_BUSY,
  output logic [29:0] oDISP_WR_ADDR,
  output logic [31:0] oDISP_WR_DATA
);

  region_t     region;
  logic        accept;
  logic        specialHit;
  logic        dispWrite;
  logic        errHit;
  logic [23:0] errCode;

  logic        fifoFull;
  logic        fifoEmpty;
  logic [61:0] fifoHead;

  logic        respValid;
  logic        respSpecialRd;
  logic [31:0] respData;

  logic        irqPend;
  logic [23:0] irqCode;

  assign region     = decodeRegion(iDEV_ADDR, P_SPECIAL_END, P_DISP_LAST);
  assign oDEV_BUSY  = fifoFull | (respValid & iDEV_BUSY);
  assign accept     = iDEV_REQ & ~oDEV_BUSY & ~iRESET_SYNC;
  assign specialHit = accept & (region == REGION_SPECIAL);
  assign dispWrite  = accept & (region == REGION_DISP) & iDEV_RW;
  assign errHit     = accept & ((region == REGION_ILLEGAL) |
                                ((region == REGION_DISP) & ~iDEV_RW));
  assign errCode    = (region == REGION_ILLEGAL) ? IRQCODE_MEMOVER : IRQCODE_READACC;

  always_comb begin
    oSPECIAL_REQ  = 1'b0;
    oSPECIAL_RW   = 1'b0;
    oSPECIAL_ADDR = '0;
    oSPECIAL_DATA = '0;
    if (specialHit) begin
      oSPECIAL_REQ  = 1'b1;
      oSPECIAL_RW   = iDEV_RW;
      oSPECIAL_ADDR = iDEV_ADDR[9:2];
      oSPECIAL_DATA = iDEV_DATA;
    end
  end

  gci_std_display_sync_fifo #(
    .P_N       (62),
    .P_DEPTH   (P_FIFO_DEPTH),
    .P_DEPTH_N (P_FIFO_AW)
  ) uFifo (
    .iCLOCK      (iCLOCK),
    .iRESET_SYNC (iRESET_SYNC),
    .iWR_EN      (dispWrite),
    .iWR_DATA    ({iDEV_ADDR[31:2], iDEV_DATA}),
    .oFULL       (fifoFull),
    .iRD_EN      (~iDISP_WR_BUSY),
    .oRD_DATA    (fifoHead),
    .oEMPTY      (fifoEmpty)
  );

  assign oDISP_WR_REQ  = ~fifoEmpty;
  assign oDISP_WR_ADDR = fifoEmpty ? '0 : fifoHead[61:32];
  assign oDISP_WR_DATA = fifoEmpty ? '0 : fifoHead[31:0];

  // Special-memory read data only arrives in the first response cycle; it is
  // forwarded combinationally then and captured so a stalled response holds.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      respValid     <= 1'b0;
      respSpecialRd <= 1'b0;
      respData      <= '0;
    end else if (accept) begin
      respValid     <= 1'b1;
      respSpecialRd <= specialHit & ~iDEV_RW;
      respData      <= '0;
    end else begin
      if (respValid & ~iDEV_BUSY) respValid <= 1'b0;
      if (respSpecialRd) begin
        respData      <= iSPECIAL_DATA;
        respSpecialRd <= 1'b0;
      end
    end
  end

  assign oDEV_REQ  = respValid;
  assign oDEV_DATA = ~respValid    ? '0 :
                     respSpecialRd ? iSPECIAL_DATA : respData;

  // A new error only replaces the slot when it is free or being acknowledged.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      irqPend <= 1'b0;
      irqCode <= '0;
    end else if (errHit && (!irqPend || iDEV_IRQ_ACK)) begin
      irqPend <= 1'b1;
      irqCode <= errCode;
    end else if (iDEV_IRQ_ACK) begin
      irqPend <= 1'b0;
    end
  end

  assign oDEV_IRQ_REQ  = irqPend & ~iDEV_IRQ_BUSY;
  assign oDEV_IRQ_DATA = irqPend ? irqCode : '0;

endmodule

// File: tb/tb_gci_std_display_bus_if.sv
module tb_gci_std_display_bus_if;

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC;
  logic        iDEV_REQ;
  logic        oDEV_BUSY;
  logic        iDEV_RW;
  logic [31:0] iDEV_ADDR;
  logic [31:0] iDEV_DATA;
  logic        oDEV_REQ;
  logic        iDEV_BUSY;
  logic [31:0] oDEV_DATA;
  logic        oDEV_IRQ_REQ;
  logic        iDEV_IRQ_BUSY;
  logic [23:0] oDEV_IRQ_DATA;
  logic        iDEV_IRQ_ACK;
  logic        oSPECIAL_REQ;
  logic        oSPECIAL_RW;
  logic [7:0]  oSPECIAL_ADDR;
  logic [31:0] oSPECIAL_DATA;
  logic [31:0] iSPECIAL_DATA;
  logic        oDISP_WR_REQ;
  logic        iDISP_WR_BUSY;
  logic [29:0] oDISP_WR_ADDR;
  logic [31:0] oDISP_WR_DATA;

  gci_std_display_bus_if dut (
    .iCLOCK        (iCLOCK),
    .iRESET_SYNC   (iRESET_SYNC),
    .iDEV_REQ      (iDEV_REQ),
    .oDEV_BUSY     (oDEV_BUSY),
    .iDEV_RW       (iDEV_RW),
    .iDEV_ADDR     (iDEV_ADDR),
    .iDEV_DATA     (iDEV_DATA),
    .oDEV_REQ      (oDEV_REQ),
    .iDEV_BUSY     (iDEV_BUSY),
    .oDEV_DATA     (oDEV_DATA),
    .oDEV_IRQ_REQ  (oDEV_IRQ_REQ),
    .iDEV_IRQ_BUSY (iDEV_IRQ_BUSY),
    .oDEV_IRQ_DATA (oDEV_IRQ_DATA),
    .iDEV_IRQ_ACK  (iDEV_IRQ_ACK),
    .oSPECIAL_REQ  (oSPECIAL_REQ),
    .oSPECIAL_RW   (oSPECIAL_RW),
    .oSPECIAL_ADDR (oSPECIAL_ADDR),
    .oSPECIAL_DATA (oSPECIAL_DATA),
    .iSPECIAL_DATA (iSPECIAL_DATA),
    .oDISP_WR_REQ  (oDISP_WR_REQ),
    .iDISP_WR_BUSY (iDISP_WR_BUSY),
    .oDISP_WR_ADDR (oDISP_WR_ADDR),
    .oDISP_WR_DATA (oDISP_WR_DATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  // External special memory: registered read, data valid one cycle after strobe.
  logic [31:0] smem [256];
  initial begin
    for (int i = 0; i < 256; i++) smem[i] = '0;
    iSPECIAL_DATA = '0;
  end
  always @(posedge iCLOCK) begin
    if (oSPECIAL_REQ) begin
      if (oSPECIAL_RW) smem[oSPECIAL_ADDR] <= oSPECIAL_DATA;
      else             iSPECIAL_DATA <= smem[oSPECIAL_ADDR];
    end
  end

  int nCmp  = 0;
  int nFail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic mid();
    @(negedge iCLOCK);
  endtask

  task automatic idleIn();
    iDEV_REQ     = 1'b0;
    iDEV_RW      = 1'b0;
    iDEV_ADDR    = '0;
    iDEV_DATA    = '0;
    iDEV_IRQ_ACK = 1'b0;
  endtask

  task automatic drive(input logic rw, input logic [31:0] addr, input logic [31:0] data);
    iDEV_REQ  = 1'b1;
    iDEV_RW   = rw;
    iDEV_ADDR = addr;
    iDEV_DATA = data;
  endtask

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic        sreq;
    logic [31:0] resp;
    logic        irq;
    logic [23:0] code;
    logic        disp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0,         1'b0, 24'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 24'h0, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 1'b1, 32'h0,         1'b0, 24'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b1, 32'h1234_5678, 1'b0, 24'h0, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0400, 32'hA5A5_0001, 1'b0, 32'h0,         1'b0, 24'h0, 1'b1};
    vecs[5]  = '{1'b1, 32'h0013_83FC, 32'h0000_0005, 1'b0, 32'h0,         1'b0, 24'h0, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0400, 32'h0,         1'b0, 32'h0,         1'b1, 24'h1, 1'b0};
    vecs[7]  = '{1'b1, 32'h0013_8400, 32'h1111_1111, 1'b0, 32'h0,         1'b1, 24'h0, 1'b0};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b0, 32'h0,         1'b1, 24'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 24'h0, 1'b0};
    vecs[10] = '{1'b1, 32'h0013_83FF, 32'h0000_0007, 1'b0, 32'h0,         1'b0, 24'h0, 1'b1};

    idleIn();
    iRESET_SYNC   = 1'b1;
    iDEV_BUSY     = 1'b0;
    iDEV_IRQ_BUSY = 1'b0;
    iDISP_WR_BUSY = 1'b0;
    nxt();
    nxt();
    mid();
    chk("rst_busy",    oDEV_BUSY,     0);
    chk("rst_req",     oDEV_REQ,      0);
    chk("rst_data",    oDEV_DATA,     0);
    chk("rst_irq",     oDEV_IRQ_REQ,  0);
    chk("rst_irqdata", oDEV_IRQ_DATA, 0);
    chk("rst_sreq",    oSPECIAL_REQ,  0);
    chk("rst_wrreq",   oDISP_WR_REQ,  0);
    chk("rst_wraddr",  oDISP_WR_ADDR, 0);
    chk("rst_wrdata",  oDISP_WR_DATA, 0);
    iRESET_SYNC = 1'b0;
    nxt();

    // Single transactions, one per table row.
    for (int i = 0; i < 11; i++) begin
      a = vecs[i].addr;
      drive(vecs[i].rw, vecs[i].addr, vecs[i].data);
      mid();
      chk("vec_busy", oDEV_BUSY, 0);
      chk("vec_sreq", oSPECIAL_REQ, vecs[i].sreq);
      if (vecs[i].sreq) begin
        chk("vec_saddr", oSPECIAL_ADDR, a[9:2]);
        chk("vec_srw",   oSPECIAL_RW,   vecs[i].rw);
        if (vecs[i].rw) chk("vec_sdata", oSPECIAL_DATA, vecs[i].data);
      end
      nxt();
      idleIn();
      iDEV_IRQ_ACK = 1'b1;
      mid();
      chk("vec_resp_req",  oDEV_REQ,      1);
      chk("vec_resp_data", oDEV_DATA,     vecs[i].resp);
      chk("vec_irq_req",   oDEV_IRQ_REQ,  vecs[i].irq);
      chk("vec_irq_code",  oDEV_IRQ_DATA, vecs[i].irq ? vecs[i].code : 24'h0);
      chk("vec_wrreq",     oDISP_WR_REQ,  vecs[i].disp);
      chk("vec_sreq_off",  oSPECIAL_REQ,  0);
      if (vecs[i].disp) begin
        chk("vec_wraddr", oDISP_WR_ADDR, a[31:2]);
        chk("vec_wrdata", oDISP_WR_DATA, vecs[i].data);
      end
      nxt();
      iDEV_IRQ_ACK = 1'b0;
      mid();
      chk("vec_resp_end", oDEV_REQ,     0);
      chk("vec_irq_end",  oDEV_IRQ_REQ, 0);
      chk("vec_wr_end",   oDISP_WR_REQ, 0);
      nxt();
    end

    // FIFO fill with a stalled controller, then drain in order.
    iDISP_WR_BUSY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i), 32'h1000 + 32'(i));
      mid();
      chk("fill_busy", oDEV_BUSY, 0);
      nxt();
    end
    drive(1'b1, 32'h420, 32'h1008);
    mid();
    chk("full_busy0",  oDEV_BUSY,     1);
    chk("full_wrreq",  oDISP_WR_REQ,  1);
    chk("full_head_a", oDISP_WR_ADDR, 30'h100);
    chk("full_head_d", oDISP_WR_DATA, 32'h1000);
    nxt();
    mid();
    chk("full_busy1", oDEV_BUSY, 1);
    nxt();
    iDISP_WR_BUSY = 1'b0;
    mid();
    chk("full_busy2", oDEV_BUSY, 1);
    nxt();
    mid();
    chk("ninth_busy", oDEV_BUSY,     0);
    chk("drain_a1",   oDISP_WR_ADDR, 30'h101);
    chk("drain_d1",   oDISP_WR_DATA, 32'h1001);
    nxt();
    idleIn();
    for (int j = 2; j <= 8; j++) begin
      mid();
      chk("drain_req", oDISP_WR_REQ,  1);
      chk("drain_a",   oDISP_WR_ADDR, 30'h100 + 30'(j));
      chk("drain_d",   oDISP_WR_DATA, 32'h1000 + 32'(j));
      nxt();
    end
    mid();
    chk("drain_empty", oDISP_WR_REQ, 0);
    nxt();

    // Response back-pressure after a special read.
    drive(1'b0, 32'h10, 32'h0);
    mid();
    nxt();
    idleIn();
    iDEV_BUSY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("hold_req",  oDEV_REQ,  1);
      chk("hold_data", oDEV_DATA, 32'hDEAD_BEEF);
      chk("hold_busy", oDEV_BUSY, 1);
      nxt();
    end
    iDEV_BUSY = 1'b0;
    mid();
    chk("rel_req",  oDEV_REQ,  1);
    chk("rel_data", oDEV_DATA, 32'hDEAD_BEEF);
    chk("rel_busy", oDEV_BUSY, 0);
    nxt();
    mid();
    chk("rel_once", oDEV_REQ, 0);
    nxt();

    // Pending READACC, second error dropped, then ACK.
    drive(1'b0, 32'h400, 32'h0);
    nxt();
    idleIn();
    mid();
    chk("ra_irq",  oDEV_IRQ_REQ,  1);
    chk("ra_code", oDEV_IRQ_DATA, 24'h1);
    chk("ra_data", oDEV_DATA,     0);
    nxt();
    drive(1'b1, 32'h138400, 32'h0);
    mid();
    chk("drop_busy", oDEV_BUSY, 0);
    nxt();
    idleIn();
    mid();
    chk("drop_resp", oDEV_REQ,      1);
    chk("drop_code", oDEV_IRQ_DATA, 24'h1);
    nxt();
    iDEV_IRQ_ACK = 1'b1;
    mid();
    chk("drop_irq", oDEV_IRQ_REQ, 1);
    nxt();
    iDEV_IRQ_ACK = 1'b0;
    mid();
    chk("ack_irq",  oDEV_IRQ_REQ,  0);
    chk("ack_code", oDEV_IRQ_DATA, 0);
    nxt();

    // IRQ channel busy masks the request but not the pending slot.
    iDEV_IRQ_BUSY = 1'b1;
    drive(1'b1, 32'h138400, 32'h0);
    nxt();
    idleIn();
    mid();
    chk("ib_masked0", oDEV_IRQ_REQ, 0);
    nxt();
    mid();
    chk("ib_masked1", oDEV_IRQ_REQ, 0);
    nxt();
    iDEV_IRQ_BUSY = 1'b0;
    mid();
    chk("ib_irq",  oDEV_IRQ_REQ,  1);
    chk("ib_code", oDEV_IRQ_DATA, 24'h0);
    iDEV_IRQ_ACK = 1'b1;
    nxt();
    iDEV_IRQ_ACK = 1'b0;
    mid();
    chk("ib_ack", oDEV_IRQ_REQ, 0);
    nxt();

    // Error and ACK in the same cycle: new code replaces the acknowledged one.
    drive(1'b0, 32'h400, 32'h0);
    nxt();
    drive(1'b1, 32'h138400, 32'h0);
    iDEV_IRQ_ACK = 1'b1;
    mid();
    chk("sa_old", oDEV_IRQ_DATA, 24'h1);
    nxt();
    idleIn();
    mid();
    chk("sa_irq",  oDEV_IRQ_REQ,  1);
    chk("sa_code", oDEV_IRQ_DATA, 24'h0);
    iDEV_IRQ_ACK = 1'b1;
    nxt();
    iDEV_IRQ_ACK = 1'b0;
    mid();
    chk("sa_ack", oDEV_IRQ_REQ, 0);
    nxt();

    // Reset with FIFO entries and an IRQ pending.
    iDISP_WR_BUSY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h800 + 32'(4 * i), 32'h2000 + 32'(i));
      nxt();
    end
    drive(1'b0, 32'h400, 32'h0);
    nxt();
    idleIn();
    mid();
    chk("pre_wrreq", oDISP_WR_REQ, 1);
    chk("pre_irq",   oDEV_IRQ_REQ, 1);
    iRESET_SYNC = 1'b1;
    nxt();
    iRESET_SYNC = 1'b0;
    mid();
    chk("mrst_wrreq", oDISP_WR_REQ,  0);
    chk("mrst_irq",   oDEV_IRQ_REQ,  0);
    chk("mrst_busy",  oDEV_BUSY,     0);
    chk("mrst_req",   oDEV_REQ,      0);
    chk("mrst_waddr", oDISP_WR_ADDR, 0);
    iDISP_WR_BUSY = 1'b0;
    nxt();
    mid();
    chk("mrst_flush", oDISP_WR_REQ, 0);
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
